acumulador_credito: RTL and testbench

Coin-credit accumulator stage that sits directly upstream of the credit comparator and drives its 5-bit credit input. It synchronises raw coin push-button inputs and detects their rising edges. It accumulates their values with saturation-by-rejection and handles purchase (subtract price) and cancel. Any leftover or cancelled credit is returned as a paced train of one-unit change pulses.

---
 rtl/acumulador_credito.sv | 192 +++++++++++++++++++
 tb/tb_acumulador_credito.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/acumulador_credito.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : acumulador_credito                                              |
// | Brief   : Coin-credit accumulator with purchase, cancel and paced change  |
// |           return. Optional debounce on coin inputs via DEBOUNCE_EN.       |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module acumulador_credito #(
   parameter int PRECIO      = 20,
   parameter int CREDITO_MAX = 31,
   parameter int DEV_CICLOS  = 4,
   parameter int DEB_CICLOS  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       moneda_1,
   input  logic       moneda_2,
   input  logic       moneda_5,
   input  logic       moneda_10,
   input  logic       consumir,
   input  logic       cancelar,
   output logic [4:0] credito,
   output logic       ocupado,
   output logic       moneda_rechazada,
   output logic       devuelve_pulso
);

   localparam int              c_CW       = (DEV_CICLOS > 1) ? $clog2(DEV_CICLOS) : 1;
   localparam logic [c_CW-1:0] c_DEV_LAST = c_CW'(DEV_CICLOS - 1);
   localparam logic [4:0]      c_PRECIO   = 5'(PRECIO);
   localparam logic [5:0]      c_CRED_MAX = 6'(CREDITO_MAX);

   if (CREDITO_MAX > 31 || CREDITO_MAX < 1 || PRECIO < 1 || PRECIO > 31 ||
       DEV_CICLOS < 1 || DEB_CICLOS < 1) begin : g_param_err
      $error("acumulador_credito: invalid parameter set");
   end

   typedef enum logic [0:0] {
      ACUM     = 1'b0,
      DEVOLVER = 1'b1
   } estado_t;

   logic [3:0]      w_crudo;
   logic [3:0]      r_sinc1;
   logic [3:0]      r_sinc2;
   logic [3:0]      w_nivel;
   logic [3:0]      r_nivel_prev;
   logic [3:0]      w_evento;
   logic [5:0]      w_valor;
   logic [5:0]      w_suma;
   logic            w_hay_moneda;

   estado_t         r_estado;
   logic [4:0]      r_credito;
   logic [c_CW-1:0] r_cnt;
   logic            r_ocupado;
   logic            r_rech;
   logic            r_pulso;

   assign w_crudo = {moneda_10, moneda_5, moneda_2, moneda_1};

   // Synchroniser resets high so a coin held through reset release is ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sinc1 <= '1;
         r_sinc2 <= '1;
      end else begin
         r_sinc1 <= w_crudo;
         r_sinc2 <= r_sinc1;
      end
   end

`ifdef DEBOUNCE_EN
   localparam int              c_DW       = $clog2(DEB_CICLOS + 1);
   localparam logic [c_DW-1:0] c_DEB_LAST = c_DW'(DEB_CICLOS - 1);

   for (genvar gi = 0; gi < 4; gi++) begin : g_deb
      logic [c_DW-1:0] r_cnt_deb;
      logic            r_deb;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_cnt_deb <= '0;
            r_deb     <= 1'b1;
         end else if (r_sinc2[gi] != r_deb) begin
            if (r_cnt_deb == c_DEB_LAST) begin
               r_deb     <= r_sinc2[gi];
               r_cnt_deb <= '0;
            end else begin
               r_cnt_deb <= r_cnt_deb + c_DW'(1);
            end
         end else begin
            r_cnt_deb <= '0;
         end
      end

      assign w_nivel[gi] = r_deb;
   end
`else
   assign w_nivel = r_sinc2;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_nivel_prev <= '1;
      end else begin
         r_nivel_prev <= w_nivel;
      end
   end

   assign w_evento     = w_nivel & ~r_nivel_prev;
   assign w_hay_moneda = |w_evento;

   // Highest-value coin wins when several edges land in the same cycle.
   always_comb begin
      w_valor = 6'd0;
      if (w_evento[3]) begin
         w_valor = 6'd10;
      end else if (w_evento[2]) begin
         w_valor = 6'd5;
      end else if (w_evento[1]) begin
         w_valor = 6'd2;
      end else if (w_evento[0]) begin
         w_valor = 6'd1;
      end
   end

   assign w_suma = {1'b0, r_credito} + w_valor;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_estado  <= ACUM;
         r_credito <= '0;
         r_cnt     <= '0;
         r_ocupado <= 1'b0;
         r_rech    <= 1'b0;
         r_pulso   <= 1'b0;
      end else begin
         r_rech  <= 1'b0;
         r_pulso <= 1'b0;
         case (r_estado)
            ACUM: begin
               if (cancelar && (r_credito != 5'd0)) begin
                  r_estado  <= DEVOLVER;
                  r_ocupado <= 1'b1;
                  r_cnt     <= '0;
                  r_rech    <= w_hay_moneda;
               end else if (consumir && (r_credito >= c_PRECIO)) begin
                  r_credito <= r_credito - c_PRECIO;
                  r_rech    <= w_hay_moneda;
                  if (r_credito != c_PRECIO) begin
                     r_estado  <= DEVOLVER;
                     r_ocupado <= 1'b1;
                     r_cnt     <= '0;
                  end
               end else if (w_hay_moneda) begin
                  if (w_suma <= c_CRED_MAX) begin
                     r_credito <= w_suma[4:0];
                  end else begin
                     r_rech <= 1'b1;
                  end
               end
            end
            DEVOLVER: begin
               r_rech <= w_hay_moneda;
               if (r_cnt == c_DEV_LAST) begin
                  r_pulso   <= 1'b1;
                  r_credito <= r_credito - 5'd1;
                  r_cnt     <= '0;
                  if (r_credito == 5'd1) begin
                     r_estado  <= ACUM;
                     r_ocupado <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + c_CW'(1);
               end
            end
            default: begin
               r_estado  <= ACUM;
               r_ocupado <= 1'b0;
            end
         endcase
      end
   end

   assign credito          = r_credito;
   assign ocupado          = r_ocupado;
   assign moneda_rechazada = r_rech;
   assign devuelve_pulso   = r_pulso;

endmodule
`default_nettype wire

// File: tb/tb_acumulador_credito.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_acumulador_credito                                           |
// | Brief   : Directed and random stimulus checked against a cycle model.     |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module tb_acumulador_credito;

   localparam int c_PRECIO = 20;
   localparam int c_MAX    = 31;
   localparam int c_DEV    = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] coins;
   logic       consumir;
   logic       cancelar;
   wire  [4:0] credito;
   wire        ocupado;
   wire        moneda_rechazada;
   wire        devuelve_pulso;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int       m_cred;
   bit       m_busy;
   int       m_wait;
   bit       m_rech;
   bit       m_pulse;
   bit [3:0] d1, d2, d3;

   always #5 clk = ~clk;

   acumulador_credito #(
      .PRECIO      (c_PRECIO),
      .CREDITO_MAX (c_MAX),
      .DEV_CICLOS  (c_DEV),
      .DEB_CICLOS  (16)
   ) u_dut (
      .clk              (clk),
      .rst              (rst),
      .moneda_1         (coins[0]),
      .moneda_2         (coins[1]),
      .moneda_5         (coins[2]),
      .moneda_10        (coins[3]),
      .consumir         (consumir),
      .cancelar         (cancelar),
      .credito          (credito),
      .ocupado          (ocupado),
      .moneda_rechazada (moneda_rechazada),
      .devuelve_pulso   (devuelve_pulso)
   );

   task automatic check(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // A coin edge is seen two edges after the raw input is first sampled high.
   task automatic model_step();
      bit [3:0] ev;
      int v;
      if (rst) begin
         m_cred = 0; m_busy = 0; m_wait = 0; m_rech = 0; m_pulse = 0;
         d1 = '1; d2 = '1; d3 = '1;
         return;
      end
      ev = d2 & ~d3;
      d3 = d2; d2 = d1; d1 = coins;
      v = ev[3] ? 10 : ev[2] ? 5 : ev[1] ? 2 : ev[0] ? 1 : 0;
      m_rech  = 0;
      m_pulse = 0;
      if (!m_busy) begin
         if (cancelar && m_cred > 0) begin
            m_busy = 1; m_wait = c_DEV; m_rech = (v != 0);
         end else if (consumir && m_cred >= c_PRECIO) begin
            m_cred = m_cred - c_PRECIO;
            m_rech = (v != 0);
            if (m_cred > 0) begin
               m_busy = 1; m_wait = c_DEV;
            end
         end else if (v != 0) begin
            if (m_cred + v <= c_MAX) m_cred = m_cred + v;
            else m_rech = 1;
         end
      end else begin
         m_rech = (v != 0);
         m_wait--;
         if (m_wait == 0) begin
            m_pulse = 1;
            m_cred--;
            m_wait = c_DEV;
            if (m_cred == 0) m_busy = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("credito", int'(credito), m_cred);
      check("ocupado", int'(ocupado), int'(m_busy));
      check("rechazada", int'(moneda_rechazada), int'(m_rech));
      check("pulso", int'(devuelve_pulso), int'(m_pulse));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic coin(input int idx);
      coins[idx] = 1'b1;
      ticks(2);
      coins[idx] = 1'b0;
      ticks(3);
   endtask

   task automatic pulse_cmd(input bit is_cancel);
      if (is_cancel) cancelar = 1'b1; else consumir = 1'b1;
      tick();
      cancelar = 1'b0;
      consumir = 1'b0;
   endtask

   initial begin
      int guard;
      rst = 1'b1; coins = '0; consumir = 1'b0; cancelar = 1'b0;
      ticks(2);
      rst = 1'b0;
      tick();
      check("rst_credito", int'(credito), 0);
      check("rst_ocupado", int'(ocupado), 0);

      // Two 10-unit coins, 3 high / 3 low
      for (int k = 0; k < 2; k++) begin
         coins[3] = 1'b1; ticks(3);
         coins[3] = 1'b0; ticks(3);
      end
      check("t1_credito", int'(credito), 20);

      // Saturation by rejection, then exact fill to the maximum
      coin(3);
      check("t2_30", int'(credito), 30);
      coin(1);
      check("t2_rej", int'(credito), 30);
      coin(0);
      check("t2_31", int'(credito), 31);

      // Empty out, then buy from 23
      pulse_cmd(1'b1);
      ticks(31 * c_DEV + 4);
      check("t3_empty", int'(credito), 0);
      coin(3); coin(3); coin(1); coin(0);
      check("t3_23", int'(credito), 23);
      pulse_cmd(1'b0);
      check("t3_after_buy", int'(credito), 3);
      check("t3_busy", int'(ocupado), 1);
      ticks(3 * c_DEV + 4);
      check("t3_done", int'(credito), 0);

      // Buy with insufficient credit, then cancel
      coin(3); coin(2);
      pulse_cmd(1'b0);
      check("t4_ignored", int'(credito), 15);
      pulse_cmd(1'b1);
      ticks(15 * c_DEV + 4);
      check("t4_done", int'(credito), 0);
      check("t4_idle", int'(ocupado), 0);

      // Simultaneous 5 and 1, then a coin during change return
      coins[2] = 1'b1; coins[0] = 1'b1; ticks(2);
      coins = '0; ticks(3);
      check("t5_plus5", int'(credito), 5);
      pulse_cmd(1'b1);
      coin(3);
      ticks(5 * c_DEV);
      check("t5_done", int'(credito), 0);

      // Reset mid-return at credit 7, with a coin held across release
      coin(3);
      pulse_cmd(1'b1);
      guard = 0;
      while (credito != 5'd7 && guard < 40) begin
         tick();
         guard++;
      end
      check("t6_reach7", int'(credito), 7);
      coins[0] = 1'b1;
      rst = 1'b1; tick();
      rst = 1'b0;
      check("t6_rst_cred", int'(credito), 0);
      ticks(6);
      coins[0] = 1'b0;
      ticks(8);
      check("t6_held", int'(credito), 0);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 5) == 0) coins[b] = ~coins[b];
         end
         consumir = ($urandom_range(0, 9) == 0);
         cancelar = ($urandom_range(0, 29) == 0);
         rst      = ($urandom_range(0, 499) == 0);
         tick();
      end
      rst = 1'b0; consumir = 1'b0; cancelar = 1'b0; coins = '0;
      ticks(10);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
